// File: rtl/spi_ctl_pkg.sv
// Shared definitions for the SPI flash read engine: spi_controller register
// indices, CPU register-window layout, CTRL/STATUS bit positions, the default
// read opcode and the read-engine FSM state type.
package spi_ctl_pkg;

  // spi_controller register port
  localparam logic [1:0] SPI_REG_RX   = 2'd1;
  localparam logic [1:0] SPI_REG_TX   = 2'd2;
  localparam logic [1:0] SPI_REG_CTRL = 2'd3;

  localparam int unsigned SPI_CTRL_BUSY_BIT = 7;
  localparam logic [7:0]  SPI_CTRL_CS_ON    = 8'h01;
  localparam logic [7:0]  SPI_CTRL_CS_OFF   = 8'h00;

  // CPU register window
  localparam logic [2:0] REG_ADDR0 = 3'd0;
  localparam logic [2:0] REG_ADDR1 = 3'd1;
  localparam logic [2:0] REG_ADDR2 = 3'd2;
  localparam logic [2:0] REG_LEN0  = 3'd3;
  localparam logic [2:0] REG_LEN1  = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;
  localparam logic [2:0] REG_CMD   = 3'd7;

  localparam int unsigned CTRL_START_BIT   = 0;
  localparam int unsigned CTRL_ABORT_BIT   = 1;
  localparam int unsigned STAT_BUSY_BIT    = 7;
  localparam int unsigned STAT_DONE_BIT    = 6;
  localparam int unsigned STAT_ABORTED_BIT = 5;

  localparam logic [7:0] DEFAULT_READ_CMD = 8'h03;

  // Opcode + 3 address bytes precede the payload; 17 bits hold 4 + 0xFFFF.
  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned CNT_W     = 17;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEL,
    ST_SEND,
    ST_GAP,
    ST_POLL,
    ST_FETCH,
    ST_HOLD,
    ST_DESEL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/spi_flash_reader_regs.sv
// CPU register window of the SPI flash reader: ADDR/LEN/CMD configuration
// registers (frozen while busy), done/aborted status flags, readback mux and
// start/abort write pulses.
//   i_clk, i_rst          clock, async active-high reset
//   i_cs/i_rwb/i_addr/i_data  CPU access
//   i_busy                engine busy (masks config writes, shown in status)
//   i_status_clr/i_done_set/i_aborted_set  status flag updates from the FSM
//   o_rdata_c             combinational readback of i_addr
//   o_flash_addr/o_len/o_cmd  configuration
//   o_start_c/o_abort_c   one-cycle write pulses from CTRL
module spi_flash_reader_regs
  import spi_ctl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs,
  input  logic        i_rwb,
  input  logic [2:0]  i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_busy,
  input  logic        i_status_clr,
  input  logic        i_done_set,
  input  logic        i_aborted_set,
  output logic [7:0]  o_rdata_c,
  output logic [23:0] o_flash_addr,
  output logic [15:0] o_len,
  output logic [7:0]  o_cmd,
  output logic        o_start_c,
  output logic        o_abort_c
);

  logic        wr_c;
  logic        cfg_wr_c;
  logic [23:0] addr_q;
  logic [15:0] len_q;
  logic [7:0]  cmd_q;
  logic        done_q;
  logic        aborted_q;

  assign wr_c      = i_cs & ~i_rwb;
  assign cfg_wr_c  = wr_c & ~i_busy;
  assign o_start_c = wr_c && (i_addr == REG_CTRL) && i_data[CTRL_START_BIT];
  assign o_abort_c = wr_c && (i_addr == REG_CTRL) && i_data[CTRL_ABORT_BIT];

  // Configuration registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q <= 24'h0;
      len_q  <= 16'h0;
      cmd_q  <= DEFAULT_READ_CMD;
    end else if (cfg_wr_c) begin
      case (i_addr)
        REG_ADDR0: addr_q[7:0]   <= i_data;
        REG_ADDR1: addr_q[15:8]  <= i_data;
        REG_ADDR2: addr_q[23:16] <= i_data;
        REG_LEN0:  len_q[7:0]    <= i_data;
        REG_LEN1:  len_q[15:8]   <= i_data;
        REG_CMD:   cmd_q         <= i_data;
        default: ;
      endcase
    end
  end

  // Status flags; a set in the same cycle as a clear wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (i_status_clr) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end
      if (i_done_set)    done_q    <= 1'b1;
      if (i_aborted_set) aborted_q <= 1'b1;
    end
  end

  // Readback mux
  always_comb begin
    o_rdata_c = 8'h00;
    case (i_addr)
      REG_ADDR0: o_rdata_c = addr_q[7:0];
      REG_ADDR1: o_rdata_c = addr_q[15:8];
      REG_ADDR2: o_rdata_c = addr_q[23:16];
      REG_LEN0:  o_rdata_c = len_q[7:0];
      REG_LEN1:  o_rdata_c = len_q[15:8];
      REG_CTRL: begin
        o_rdata_c[STAT_BUSY_BIT]    = i_busy;
        o_rdata_c[STAT_DONE_BIT]    = done_q;
        o_rdata_c[STAT_ABORTED_BIT] = aborted_q;
      end
      REG_CMD:   o_rdata_c = cmd_q;
      default: ;
    endcase
  end

  assign o_flash_addr = addr_q;
  assign o_len        = len_q;
  assign o_cmd        = cmd_q;

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash read engine. Masters the spi_controller register port to send
// opcode + 24-bit address + one 0xFF per payload byte, and streams each payload
// RX byte on a valid/ready interface.
//   i_clk, i_rst                  clock, async active-high reset
//   i_cs/i_rwb/i_addr/i_data      CPU register window, o_data readback
//   o_ctl_cs/rwb/addr/data        one-cycle strobes to spi_controller
//   i_ctl_data                    spi_controller read data
//   o_byte/o_byte_valid/i_byte_ready  payload stream
module spi_flash_reader
  import spi_ctl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cs,
  input  logic       i_rwb,
  input  logic [2:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_ctl_cs,
  output logic       o_ctl_rwb,
  output logic [1:0] o_ctl_addr,
  output logic [7:0] o_ctl_data,
  input  logic [7:0] i_ctl_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  input  logic       i_byte_ready
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic               abort_pend_q, abort_pend_d;
  logic [7:0]         byte_q, byte_d;
  logic               byte_valid_q, byte_valid_d;
  logic               ctl_cs_q, ctl_cs_d;
  logic               ctl_rwb_q, ctl_rwb_d;
  logic [1:0]         ctl_addr_q, ctl_addr_d;
  logic [7:0]         ctl_data_q, ctl_data_d;

  logic               busy_c;
  logic               start_c;
  logic               abort_c;
  logic               abort_now_c;
  logic               status_clr_c;
  logic               done_set_c;
  logic               aborted_set_c;
  logic [7:0]         tx_byte_c;
  logic [23:0]        flash_addr;
  logic [15:0]        len;
  logic [7:0]         cmd;

  assign busy_c = (state_q != ST_IDLE);

  spi_flash_reader_regs u_regs (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_cs          (i_cs),
    .i_rwb         (i_rwb),
    .i_addr        (i_addr),
    .i_data        (i_data),
    .i_busy        (busy_c),
    .i_status_clr  (status_clr_c),
    .i_done_set    (done_set_c),
    .i_aborted_set (aborted_set_c),
    .o_rdata_c     (o_data),
    .o_flash_addr  (flash_addr),
    .o_len         (len),
    .o_cmd         (cmd),
    .o_start_c     (start_c),
    .o_abort_c     (abort_c)
  );

  // State and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      sent_q       <= '0;
      total_q      <= '0;
      abort_pend_q <= 1'b0;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      ctl_cs_q     <= 1'b0;
      ctl_rwb_q    <= 1'b1;
      ctl_addr_q   <= 2'd0;
      ctl_data_q   <= 8'hFF;
    end else begin
      state_q      <= state_d;
      sent_q       <= sent_d;
      total_q      <= total_d;
      abort_pend_q <= abort_pend_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      ctl_cs_q     <= ctl_cs_d;
      ctl_rwb_q    <= ctl_rwb_d;
      ctl_addr_q   <= ctl_addr_d;
      ctl_data_q   <= ctl_data_d;
    end
  end

  // Next-state logic. DONE is folded into the transition that reaches it:
  // done is flagged and the FSM lands directly in IDLE.
  always_comb begin
    state_d       = state_q;
    sent_d        = sent_q;
    total_d       = total_q;
    abort_pend_d  = abort_pend_q;
    byte_d        = byte_q;
    byte_valid_d  = byte_valid_q;
    status_clr_c  = 1'b0;
    done_set_c    = 1'b0;
    aborted_set_c = 1'b0;
    abort_now_c   = abort_pend_q | abort_c;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          status_clr_c = 1'b1;
          if (len == 16'd0) begin
            done_set_c = 1'b1;
          end else begin
            total_d      = CNT_W'(len) + CNT_W'(HDR_BYTES);
            sent_d       = '0;
            abort_pend_d = 1'b0;
            state_d      = ST_SEL;
          end
        end
      end
      ST_SEL:  state_d = ST_SEND;
      ST_SEND: begin
        sent_d  = sent_q + CNT_W'(1);
        state_d = ST_GAP;
      end
      ST_GAP:  state_d = ST_POLL;
      ST_POLL: begin
        if (!i_ctl_data[SPI_CTRL_BUSY_BIT]) begin
          if (abort_now_c)                    state_d = ST_DESEL;
          else if (sent_q > CNT_W'(HDR_BYTES)) state_d = ST_FETCH;
          else                                 state_d = ST_SEND;
        end
      end
      ST_FETCH: begin
        if (abort_now_c) begin
          state_d = ST_DESEL;
        end else begin
          byte_d       = i_ctl_data;
          byte_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (abort_now_c) begin
          byte_valid_d = 1'b0;
          state_d      = ST_DESEL;
        end else if (i_byte_ready) begin
          byte_valid_d = 1'b0;
          state_d      = (sent_q < total_q) ? ST_SEND : ST_DESEL;
        end
      end
      ST_DESEL: begin
        done_set_c    = 1'b1;
        aborted_set_c = abort_now_c;
        state_d       = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort only latches while an operation is running
    if (busy_c && abort_c) abort_pend_d = 1'b1;
  end

  // TX byte for the transfer about to be sent
  always_comb begin
    tx_byte_c = 8'hFF;
    case (sent_d)
      CNT_W'(0): tx_byte_c = cmd;
      CNT_W'(1): tx_byte_c = flash_addr[23:16];
      CNT_W'(2): tx_byte_c = flash_addr[15:8];
      CNT_W'(3): tx_byte_c = flash_addr[7:0];
      default:   tx_byte_c = 8'hFF;
    endcase
  end

  // Controller strobe for the state being entered, registered with it
  always_comb begin
    ctl_cs_d   = 1'b0;
    ctl_rwb_d  = 1'b1;
    ctl_addr_d = 2'd0;
    ctl_data_d = 8'hFF;
    case (state_d)
      ST_SEL: begin
        ctl_cs_d   = 1'b1;
        ctl_rwb_d  = 1'b0;
        ctl_addr_d = SPI_REG_CTRL;
        ctl_data_d = SPI_CTRL_CS_ON;
      end
      ST_SEND: begin
        ctl_cs_d   = 1'b1;
        ctl_rwb_d  = 1'b0;
        ctl_addr_d = SPI_REG_TX;
        ctl_data_d = tx_byte_c;
      end
      ST_POLL: begin
        ctl_cs_d   = 1'b1;
        ctl_addr_d = SPI_REG_CTRL;
      end
      ST_FETCH: begin
        ctl_cs_d   = 1'b1;
        ctl_addr_d = SPI_REG_RX;
      end
      ST_DESEL: begin
        ctl_cs_d   = 1'b1;
        ctl_rwb_d  = 1'b0;
        ctl_addr_d = SPI_REG_CTRL;
        ctl_data_d = SPI_CTRL_CS_OFF;
      end
      default: ;
    endcase
  end

  assign o_ctl_cs     = ctl_cs_q;
  assign o_ctl_rwb    = ctl_rwb_q;
  assign o_ctl_addr   = ctl_addr_q;
  assign o_ctl_data   = ctl_data_q;
  assign o_byte       = byte_q;
  assign o_byte_valid = byte_valid_q;

endmodule
